// File: rtl/simmem_delay_scheduler.sv
// -----------------------------------------------------------------------------
// simmem_delay_scheduler
//
// Purpose:
//   Sits between the delay calculator and the write-response message bank of
//   the simulated memory controller. Each accepted (bank address, delay) pair
//   is parked in a timer slot. When the slot's delay has elapsed, the slot
//   becomes eligible for release. Eligible slots are granted round-robin, and
//   a grant is held until the message bank takes it.
//
// Handshakes (both sides):
//   A transfer happens on a rising clk_i edge where valid and ready are both 1.
//   The source holds its payload stable while valid is high and ready is low.
//   ready never depends combinationally on valid on the same interface.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   in_valid_i   new scheduling request valid
//   in_ready_o   at least one slot is free (registered state only)
//   in_addr_i    bank address to release later
//   in_delay_i   delay in cycles
//   rel_valid_o  release request valid
//   rel_ready_i  message bank accepts the release
//   rel_addr_o   bank address to release (0 while rel_valid_o is low)
//   occupancy_o  number of non-FREE slots (registered)
// -----------------------------------------------------------------------------
module simmem_delay_scheduler #(
    parameter int NumSlots      = 8,
    parameter int BankAddrWidth = 3,
    parameter int DelayWidth    = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [BankAddrWidth-1:0]        in_addr_i,
    input  logic [DelayWidth-1:0]           in_delay_i,
    output logic                            rel_valid_o,
    input  logic                            rel_ready_i,
    output logic [BankAddrWidth-1:0]        rel_addr_o,
    output logic [$clog2(NumSlots+1)-1:0]   occupancy_o
);

    localparam int IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int OccWidth = $clog2(NumSlots + 1);

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_COUNTING = 2'd1,
        SLOT_EXPIRED  = 2'd2
    } slot_state_e;

    // Per-slot state; slot_state_q doubles as the observable FSM state.
    slot_state_e                slot_state_q [NumSlots];
    slot_state_e                slot_state_d [NumSlots];
    logic [BankAddrWidth-1:0]   slot_addr_q  [NumSlots];
    logic [DelayWidth-1:0]      slot_cnt_q   [NumSlots];

    logic [IdxWidth-1:0]        ptr_q;
    logic [IdxWidth-1:0]        grant_q;
    logic                       lock_q;
    logic [OccWidth-1:0]        occ_q;

    logic [NumSlots-1:0]        free_vec;
    logic [NumSlots-1:0]        expired_vec;
    logic                       any_free;
    logic                       any_expired;
    logic [IdxWidth-1:0]        free_idx;
    logic [IdxWidth-1:0]        sel_idx;
    logic                       sel_found;
    logic [IdxWidth-1:0]        cand;
    logic [IdxWidth-1:0]        grant_idx;
    logic [IdxWidth-1:0]        ptr_next;
    logic                       accept;
    logic                       release_hs;

    // -------------------------------------------------------------------------
    // Slot status vectors
    // -------------------------------------------------------------------------
    always_comb begin
        free_vec    = '0;
        expired_vec = '0;
        for (int i = 0; i < NumSlots; i++) begin
            free_vec[i]    = (slot_state_q[i] == SLOT_FREE);
            expired_vec[i] = (slot_state_q[i] == SLOT_EXPIRED);
        end
    end

    assign any_free    = |free_vec;
    assign any_expired = |expired_vec;

    // Lowest-index free slot; scanning downward leaves the lowest match last.
    always_comb begin
        free_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx = IdxWidth'(i);
            end
        end
    end

    // First expired slot at or after the pointer, wrapping modulo NumSlots.
    always_comb begin
        sel_idx   = ptr_q;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NumSlots; k++) begin
            cand = IdxWidth'((int'(ptr_q) + k) % NumSlots);
            if (!sel_found && expired_vec[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake signals
    // -------------------------------------------------------------------------
    // While locked, the latched grant is presented even if other slots have
    // expired meanwhile; otherwise the fresh round-robin choice is shown.
    // The reset gate keeps a stale expired slot from being offered in the
    // reset cycle itself.
    assign grant_idx   = lock_q ? grant_q : sel_idx;
    assign rel_valid_o = (lock_q || any_expired) && !rst_i;
    assign rel_addr_o  = rel_valid_o ? slot_addr_q[grant_idx] : '0;
    assign release_hs  = rel_valid_o && rel_ready_i;

    assign in_ready_o  = any_free;
    assign accept      = in_valid_i && any_free;

    assign ptr_next    = (grant_idx == IdxWidth'(NumSlots - 1)) ? '0
                                                                 : grant_idx + 1'b1;
    assign occupancy_o = occ_q;

    // -------------------------------------------------------------------------
    // Per-slot FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            slot_state_d[i] = slot_state_q[i];
            case (slot_state_q[i])
                SLOT_FREE: begin
                    if (accept && (free_idx == IdxWidth'(i))) begin
                        slot_state_d[i] = SLOT_COUNTING;
                    end
                end
                SLOT_COUNTING: begin
                    // A zero count means the delay has fully elapsed.
                    if (slot_cnt_q[i] == '0) begin
                        slot_state_d[i] = SLOT_EXPIRED;
                    end
                end
                SLOT_EXPIRED: begin
                    if (release_hs && (grant_idx == IdxWidth'(i))) begin
                        slot_state_d[i] = SLOT_FREE;
                    end
                end
                default: begin
                    slot_state_d[i] = SLOT_FREE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSlots; i++) begin
                slot_state_q[i] <= SLOT_FREE;
                slot_addr_q[i]  <= '0;
                slot_cnt_q[i]   <= '0;
            end
            ptr_q   <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            occ_q   <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                slot_state_q[i] <= slot_state_d[i];
                if ((slot_state_q[i] == SLOT_FREE) && accept &&
                    (free_idx == IdxWidth'(i))) begin
                    slot_addr_q[i] <= in_addr_i;
                    slot_cnt_q[i]  <= in_delay_i;
                end else if ((slot_state_q[i] == SLOT_COUNTING) &&
                             (slot_cnt_q[i] != '0)) begin
                    slot_cnt_q[i] <= slot_cnt_q[i] - 1'b1;
                end
            end

            if (release_hs) begin
                ptr_q  <= ptr_next;
                lock_q <= 1'b0;
            end else if (rel_valid_o && !lock_q) begin
                // Offered but not taken: freeze this choice until handshake.
                lock_q  <= 1'b1;
                grant_q <= sel_idx;
            end

            // Simultaneous accept and release cancel out.
            case ({accept, release_hs})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_simmem_delay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_simmem_delay_scheduler
//
// Directed bench for simmem_delay_scheduler. The stimulus process pushes the
// expected release addresses into exp_q; an independent monitor pops and
// compares on every release handshake, and also checks that a pending grant
// stays stable. Timing and boundary checks are made inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_simmem_delay_scheduler;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_addr;
    logic [5:0] in_delay;
    logic       rel_valid;
    logic       rel_ready;
    logic [2:0] rel_addr;
    logic [3:0] occ;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         edge_cnt = 0;
    int         acc;
    int         stale;

    logic [2:0] exp_q[$];
    bit         live [8];

    simmem_delay_scheduler #(
        .NumSlots      (8),
        .BankAddrWidth (3),
        .DelayWidth    (6)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_addr_i   (in_addr),
        .in_delay_i  (in_delay),
        .rel_valid_o (rel_valid),
        .rel_ready_i (rel_ready),
        .rel_addr_o  (rel_addr),
        .occupancy_o (occ)
    );

    // ---------------- clock / edge counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the accept edge.
    task automatic accept(input logic [2:0] a, input logic [5:0] d, input bit push);
        in_valid = 1'b1;
        in_addr  = a;
        in_delay = d;
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        assert (!live[a]) else $error("duplicate live bank address %0d", a);
        live[a] = 1'b1;
        if (push) exp_q.push_back(a);
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from the accept edge until rel_valid is first seen high.
    task automatic wait_rise(input string name, input int acc_edge, input int exp_edges);
        int n;
        n = 0;
        @(negedge clk);
        while (!rel_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, edge_cnt - acc_edge, exp_edges);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       prev_pend;
        logic [2:0] prev_addr;
        logic [2:0] exp_a;
        prev_pend = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    check("hold_valid", rel_valid, 1);
                    check("hold_addr", rel_addr, prev_addr);
                end
                if (rel_valid && rel_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_release: got addr %0d, expected none (t=%0t)",
                                 rel_addr, $time);
                    end else begin
                        exp_a = exp_q.pop_front();
                        check("release_addr", rel_addr, exp_a);
                    end
                    live[rel_addr] = 1'b0;
                end
                prev_pend = rel_valid && !rel_ready;
                prev_addr = rel_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_delay  = '0;
        rel_ready = 1'b0;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_rel_valid", rel_valid, 0);
        check("rst_rel_addr", rel_addr, 0);
        check("rst_occ", occ, 0);
        tick();
        rst = 1'b0;

        // T1: delay 0 -> release one edge after accept, occupancy 0->1->0
        rel_ready = 1'b1;
        check("t1_occ_before", occ, 0);
        accept(3'd5, 6'd0, 1'b1);
        acc = edge_cnt;
        wait_rise("t1_rise", acc, 1);
        check("t1_addr", rel_addr, 5);
        check("t1_occ_busy", occ, 1);
        @(negedge clk);
        check("t1_valid_low", rel_valid, 0);
        check("t1_occ_after", occ, 0);
        tick();

        // T2: delay 10 -> +11 edges, delay 63 -> +64 edges (no wrap)
        accept(3'd2, 6'd10, 1'b1);
        acc = edge_cnt;
        wait_rise("t2_rise_d10", acc, 11);
        check("t2_addr_d10", rel_addr, 2);
        tick();
        accept(3'd3, 6'd63, 1'b1);
        acc = edge_cnt;
        wait_rise("t2_rise_d63", acc, 64);
        check("t2_addr_d63", rel_addr, 3);
        tick();

        // T3: fill all slots, then offer more while full
        rel_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            accept(3'(i), 6'(20 + i), 1'b1);
        end
        in_valid = 1'b1;
        in_addr  = 3'd5;
        in_delay = 6'd1;
        repeat (5) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            check("full_occ", occ, 8);
            tick();
        end
        in_valid = 1'b0;
        repeat (40) tick();
        rel_ready = 1'b1;
        wait_drain("t3_drain", 100);
        tick();
        @(negedge clk);
        check("t3_occ_empty", occ, 0);
        check("t3_in_ready", in_ready, 1);
        tick();

        // T4: three expire while ready is low; grant on addr 0 held, then 0,1,2 back to back
        rel_ready = 1'b0;
        accept(3'd0, 6'd4, 1'b1);
        accept(3'd1, 6'd4, 1'b1);
        accept(3'd2, 6'd4, 1'b1);
        acc = edge_cnt;
        wait_rise("t4_rise", acc, 3);
        repeat (4) begin
            @(negedge clk);
            check("t4_hold_valid", rel_valid, 1);
            check("t4_hold_addr", rel_addr, 0);
        end
        tick();
        rel_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_seq_valid", rel_valid, 1);
            check("t4_seq_addr", rel_addr, i);
        end
        @(negedge clk);
        check("t4_done_valid", rel_valid, 0);
        check("t4_done_occ", occ, 0);
        tick();

        // T5: pointer is 3; slots 1 and 6 expire on the same edge -> 6 then 1
        rel_ready = 1'b0;
        accept(3'd0, 6'd63, 1'b0);
        accept(3'd1, 6'd7,  1'b0);
        accept(3'd2, 6'd63, 1'b0);
        accept(3'd3, 6'd63, 1'b0);
        accept(3'd4, 6'd63, 1'b0);
        accept(3'd5, 6'd63, 1'b0);
        accept(3'd6, 6'd2,  1'b0);
        acc = edge_cnt;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd5);
        wait_rise("t5_rise", acc, 3);
        check("t5_first_grant", rel_addr, 6);
        check("t5_occ", occ, 7);
        tick();
        rel_ready = 1'b1;
        wait_drain("t5_drain", 200);
        tick();

        // T6: reset with four slots counting and one grant pending
        rel_ready = 1'b0;
        accept(3'd7, 6'd0,  1'b0);
        accept(3'd1, 6'd40, 1'b0);
        accept(3'd2, 6'd40, 1'b0);
        accept(3'd3, 6'd40, 1'b0);
        accept(3'd4, 6'd40, 1'b0);
        @(negedge clk);
        check("t6_pending_valid", rel_valid, 1);
        check("t6_pending_addr", rel_addr, 7);
        check("t6_occ", occ, 5);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_cycle_valid", rel_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) live[i] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_post_valid", rel_valid, 0);
        check("t6_post_occ", occ, 0);
        check("t6_post_ready", in_ready, 1);
        tick();
        rel_ready = 1'b1;
        stale = 0;
        repeat (70) begin
            @(negedge clk);
            if (rel_valid) stale++;
        end
        check("t6_no_stale_release", stale, 0);
        check("end_occ", occ, 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simmem_delay_scheduler.md
Name: simmem_delay_scheduler

Overview:
- Scheduler between the delay calculator and the write-response message bank of the simulated memory controller.
- Accepts one (bank address, delay) pair per handshake and holds it in one of NumSlots timer slots.
- When a slot's delay elapses, it issues a release request carrying that bank address.
- When several slots are expired, it arbitrates between them round-robin, with a grant held stable until handshake.

Parameters:
- NumSlots, 8, number of timer slots; each slot tracks one outstanding message.
- BankAddrWidth, 3, width of the message-bank address carried through each slot.
- DelayWidth, 6, width of the delay value, in cycles.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  new scheduling request valid.
- in_ready_o  out  1  a free slot exists.
- in_addr_i  in  BankAddrWidth  bank address to release later.
- in_delay_i  in  DelayWidth  delay in cycles.
- rel_valid_o  out  1  release request valid.
- rel_ready_i  in  1  message bank accepts the release.
- rel_addr_o  out  BankAddrWidth  bank address to release.
- occupancy_o  out  $clog2(NumSlots+1)  number of non-FREE slots.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - all slots FREE;
  - round-robin pointer = 0;
  - grant lock cleared;
  - in_ready_o = 1, rel_valid_o = 0, rel_addr_o = 0, occupancy_o = 0.
- Reset asserted mid-operation discards all pending slots. No release is emitted in the reset cycle or the cycle after it.
- Per-slot state machine: FREE -> COUNTING -> EXPIRED -> FREE. Each slot stores addr[BankAddrWidth] and cnt[DelayWidth].
- Accept:
  - in_ready_o = OR of FREE slots, computed from registered state only.
  - On in_valid_i && in_ready_o, the lowest-index FREE slot loads cnt = in_delay_i and addr = in_addr_i, and goes COUNTING.
- COUNTING:
  - Each edge: if cnt == 0, go EXPIRED; otherwise cnt decrements by 1.
  - cnt never wraps.
  - Delay d therefore makes the slot EXPIRED d+1 edges after the accept edge. d = 0 gives release eligibility in the first cycle after accept.
- Release arbitration:
  - When the grant is unlocked and at least one slot is EXPIRED, select the first EXPIRED slot at or after the pointer, searching upward modulo NumSlots.
  - rel_valid_o = 1 and rel_addr_o = that slot's addr. Both are driven from registered state, with no combinational path from rel_ready_i.
  - The grant is latched; rel_valid_o and rel_addr_o are held stable until the handshake, even if other slots expire meanwhile.
- Handshake (rel_valid_o && rel_ready_i):
  - the granted slot goes FREE;
  - the pointer becomes (grant + 1) mod NumSlots;
  - the lock clears.
  - A new grant may be presented in the very next cycle, giving one release per cycle sustained.
- Simultaneous events:
  - A slot freed by a release handshake is not available to an accept in the same cycle; in_ready_o reflects pre-edge state.
  - Accept and release in the same cycle leave occupancy_o unchanged.
- Full: all slots non-FREE, so in_ready_o = 0 and in_valid_i is ignored. in_addr_i and in_delay_i need not be held by this block's contract, since nothing is captured.
- Empty: rel_valid_o = 0.
- occupancy_o is registered; it increments on accept and decrements on release.
- Duplicate in_addr_i values among live slots are illegal. The bench must flag them with an assertion; the RTL does not check them.

Test Plan:
- Reset, then accept addr=5, delay=0 at cycle 1 with rel_ready_i=1: rel_valid_o=1 with rel_addr_o=5 at cycle 2, and low at cycle 3; occupancy_o goes 0->1->0.
- Accept addr=2, delay=10 with rel_ready_i=1: rel_valid_o rises exactly 11 cycles after the accept edge. Repeat with delay=63 and check rise at +64 cycles, with no wrap.
- Fill all 8 slots (delays 20..27), then drive in_valid_i for 5 more cycles: in_ready_o=0, occupancy_o=8, and no extra slot is captured.
- Accept addrs 0,1,2 at the same cycle offset with equal delay, holding rel_ready_i=0 for 4 cycles: rel_addr_o stays 0 and stable. Then with ready high, releases come out 0,1,2 on consecutive cycles.
- With the pointer at 3 after a release, expire slots 1 and 6 together: the grant goes to 6 first, then 1 (round-robin wrap).
- Assert rst_i with 4 slots COUNTING and one grant pending: the next cycle shows rel_valid_o=0, occupancy_o=0 and in_ready_o=1, and no stale release appears within 70 cycles.
